// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the byte-enabled RAM access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_ILL  = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // The reserved width encoding is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input width_e w, input logic [1:0] lo);
        case (w)
            W_BYTE:  is_misaligned = 1'b0;
            W_HALF:  is_misaligned = lo[0];
            W_WORD:  is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_byte_en(input width_e w, input logic [1:0] lo);
        case (w)
            W_BYTE:  store_byte_en = 4'b0001 << lo;
            W_HALF:  store_byte_en = 4'b0011 << {lo[1], 1'b0};
            W_WORD:  store_byte_en = 4'b1111;
            default: store_byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input width_e w, input logic [31:0] d);
        case (w)
            W_BYTE:  store_lanes = {4{d[7:0]}};
            W_HALF:  store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, response and RAM-side signals of the memory access controller.
interface mem_access_ctrl_if #(parameter int ADDR_WIDTH = 14);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_width;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [3:0]            mem_write_en;
    logic [31:0]           mem_dout;

    modport master (
        output req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_din, mem_write_en
    );

    modport slave (
        input  req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_din, mem_write_en
    );
endinterface

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Selects the addressed byte/half lane of a RAM word and sign- or zero-extends it.
// Purely combinational; no state, no backpressure.
module load_align_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  addr_lo,
    input  width_e      width,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = dout[7:0];
            2'd1:    byte_sel = dout[15:8];
            2'd2:    byte_sel = dout[23:16];
            default: byte_sel = dout[31:24];
        endcase
        half_sel = addr_lo[1] ? dout[31:16] : dout[15:0];

        case (width)
            W_BYTE:  result = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            W_HALF:  result = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default: result = dout;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a 32-bit byte-enabled synchronous RAM; one access in flight.
// Latency: misaligned 1, store 2, load 3 cycles after acceptance; response cannot be stalled.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus
);
    state_e                state_q, state_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    width_e                width_q, width_d;
    logic                  unsigned_q, unsigned_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_din_q, mem_din_d;
    logic [3:0]            mem_we_q, mem_we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;

    width_e      req_width;
    logic [31:0] load_data;
    logic        unused_addr_bits;

    assign req_width        = width_e'(bus.req_width);
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

    load_align_ext u_align (
        .dout        (bus.mem_dout),
        .addr_lo     (addr_lo_q),
        .width       (width_q),
        .is_unsigned (unsigned_q),
        .result      (load_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        width_d      = width_q;
        unsigned_d   = unsigned_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 4'b0000;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_lo_d  = bus.req_addr[1:0];
                    width_d    = req_width;
                    unsigned_d = bus.req_unsigned;
                    we_d       = bus.req_we;
                    if (is_misaligned(req_width, bus.req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d    = ST_ISSUE;
                        mem_addr_d = bus.req_addr[ADDR_WIDTH+1:2];
                        mem_din_d  = store_lanes(req_width, bus.req_wdata);
                        mem_we_d   = bus.req_we ? store_byte_en(req_width, bus.req_addr[1:0]) : 4'b0000;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            // RAM read data for the address driven in ISSUE is present now.
            ST_WAIT: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_mis_d   = 1'b0;
                resp_rdata_d = load_data;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_lo_q    <= 2'b00;
            width_q      <= W_BYTE;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'h0;
            mem_we_q     <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            width_q      <= width_d;
            unsigned_q   <= unsigned_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    assign bus.req_ready       = (state_q == ST_IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_din         = mem_din_q;
    assign bus.mem_write_en    = mem_we_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural one-cycle-latency byte-enabled RAM.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_WIDTH(14)) bus_if ();

    mem_access_ctrl #(.ADDR_WIDTH(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    logic [31:0] ram [0:16383];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus_if.mem_write_en[b])
                ram[bus_if.mem_addr][8*b +: 8] <= bus_if.mem_din[8*b +: 8];
        bus_if.mem_dout <= ram[bus_if.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, scrambles the inputs after acceptance, and checks the whole exchange.
    task automatic run_req(input string tag, input logic we, input logic [1:0] w, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                           input logic [3:0] exp_we, input logic [31:0] exp_maddr,
                           input logic [31:0] exp_din, input logic [31:0] exp_rdata, input logic exp_mis);
        int          lat;
        logic [3:0]  we_or;
        logic [31:0] maddr1, din1;
        logic        ready_seen;
        bus_if.req_valid    = 1'b1;
        bus_if.req_we       = we;
        bus_if.req_width    = w;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wdata;
        lat = 0; we_or = 4'b0000; ready_seen = 1'b0; maddr1 = 32'h0; din1 = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                bus_if.req_valid    = 1'b0;
                bus_if.req_we       = ~we;
                bus_if.req_width    = 2'b11;
                bus_if.req_unsigned = ~uns;
                bus_if.req_addr     = 32'hFFFF_FFFF;
                bus_if.req_wdata    = 32'h5A5A_5A5A;
                maddr1 = 32'(bus_if.mem_addr);
                din1   = bus_if.mem_din;
            end
            we_or |= bus_if.mem_write_en;
            if (bus_if.req_ready) ready_seen = 1'b1;
            if (bus_if.resp_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/write_en"}, 32'(we_or), 32'(exp_we));
        check({tag, "/mem_addr"}, maddr1, exp_maddr);
        if (we && !exp_mis) check({tag, "/mem_din"}, din1, exp_din);
        check({tag, "/rdata"}, bus_if.resp_rdata, exp_rdata);
        check({tag, "/misaligned"}, 32'(bus_if.resp_misaligned), 32'(exp_mis));
        check({tag, "/ready_busy"}, 32'(ready_seen), 32'h0);
        tick();
        check({tag, "/pulse_end"}, 32'(bus_if.resp_valid), 32'h0);
        check({tag, "/ready_idle"}, 32'(bus_if.req_ready), 32'h1);
        check({tag, "/rdata_hold"}, bus_if.resp_rdata, exp_rdata);
    endtask

    initial begin
        logic resp_seen;
        reset_n             = 1'b0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_we       = 1'b0;
        bus_if.req_width    = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_wdata    = 32'h0;
        tick();
        tick();
        check("rst/resp_valid", 32'(bus_if.resp_valid), 32'h0);
        check("rst/rdata", bus_if.resp_rdata, 32'h0);
        check("rst/misaligned", 32'(bus_if.resp_misaligned), 32'h0);
        check("rst/write_en", 32'(bus_if.mem_write_en), 32'h0);
        check("rst/mem_addr", 32'(bus_if.mem_addr), 32'h0);
        check("rst/mem_din", bus_if.mem_din, 32'h0);
        reset_n = 1'b1;
        tick();
        check("rst/ready", 32'(bus_if.req_ready), 32'h1);

        //       tag          we    width   uns   addr          wdata         lat we      maddr  din           rdata         mis
        run_req("st_w_10",    1'b1, W_WORD, 1'b0, 32'h10,       32'hDEADBEEF, 2, 4'hF, 32'h4, 32'hDEADBEEF, 32'h0,        1'b0);
        run_req("st_w_20",    1'b1, W_WORD, 1'b0, 32'h20,       32'hAAAAAAAA, 2, 4'hF, 32'h8, 32'hAAAAAAAA, 32'h0,        1'b0);
        run_req("ld_w_10",    1'b0, W_WORD, 1'b0, 32'h10,       32'h0,        3, 4'h0, 32'h4, 32'h0,        32'hDEADBEEF, 1'b0);
        run_req("st_b_13",    1'b1, W_BYTE, 1'b0, 32'h13,       32'h12345680, 2, 4'h8, 32'h4, 32'h80808080, 32'h0,        1'b0);
        run_req("ld_bs_13",   1'b0, W_BYTE, 1'b0, 32'h13,       32'h0,        3, 4'h0, 32'h4, 32'h0,        32'hFFFFFF80, 1'b0);
        run_req("ld_bu_13",   1'b0, W_BYTE, 1'b1, 32'h13,       32'h0,        3, 4'h0, 32'h4, 32'h0,        32'h00000080, 1'b0);
        run_req("st_h_22",    1'b1, W_HALF, 1'b0, 32'h22,       32'hFFFF1234, 2, 4'hC, 32'h8, 32'h12341234, 32'h0,        1'b0);
        run_req("ld_w_20",    1'b0, W_WORD, 1'b0, 32'h20,       32'h0,        3, 4'h0, 32'h8, 32'h0,        32'h1234AAAA, 1'b0);
        run_req("ld_hs_20",   1'b0, W_HALF, 1'b0, 32'h20,       32'h0,        3, 4'h0, 32'h8, 32'h0,        32'hFFFFAAAA, 1'b0);
        run_req("ld_hu_22",   1'b0, W_HALF, 1'b1, 32'h22,       32'h0,        3, 4'h0, 32'h8, 32'h0,        32'h00001234, 1'b0);
        run_req("ld_bu_21",   1'b0, W_BYTE, 1'b1, 32'h21,       32'h0,        3, 4'h0, 32'h8, 32'h0,        32'h000000AA, 1'b0);
        run_req("ld_bs_12",   1'b0, W_BYTE, 1'b0, 32'h12,       32'h0,        3, 4'h0, 32'h4, 32'h0,        32'hFFFFFFAD, 1'b0);
        run_req("mis_h_01",   1'b0, W_HALF, 1'b0, 32'h01,       32'h0,        1, 4'h0, 32'h4, 32'h0,        32'h0,        1'b1);
        run_req("mis_w_06",   1'b0, W_WORD, 1'b0, 32'h06,       32'h0,        1, 4'h0, 32'h4, 32'h0,        32'h0,        1'b1);
        run_req("mis_ill_00", 1'b0, W_ILL,  1'b0, 32'h00,       32'h0,        1, 4'h0, 32'h4, 32'h0,        32'h0,        1'b1);
        run_req("mis_st_12",  1'b1, W_WORD, 1'b0, 32'h12,       32'h0,        1, 4'h0, 32'h4, 32'h0,        32'h0,        1'b1);
        run_req("ld_w_10b",   1'b0, W_WORD, 1'b0, 32'h10,       32'h0,        3, 4'h0, 32'h4, 32'h0,        32'h80ADBEEF, 1'b0);
        run_req("st_w_hi",    1'b1, W_WORD, 1'b0, 32'h00010030, 32'hCAFEF00D, 2, 4'hF, 32'hC, 32'hCAFEF00D, 32'h0,        1'b0);
        run_req("ld_w_30",    1'b0, W_WORD, 1'b0, 32'h30,       32'h0,        3, 4'h0, 32'hC, 32'h0,        32'hCAFEF00D, 1'b0);

        // Back-to-back: req_valid held; address changed after the first acceptance.
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_width = W_WORD;
        bus_if.req_addr  = 32'h10;
        tick();
        check("b2b/issue_ready", 32'(bus_if.req_ready), 32'h0);
        check("b2b/issue_addr", 32'(bus_if.mem_addr), 32'h4);
        bus_if.req_addr = 32'h20;
        tick();
        check("b2b/wait_ready", 32'(bus_if.req_ready), 32'h0);
        tick();
        check("b2b/resp1_valid", 32'(bus_if.resp_valid), 32'h1);
        check("b2b/resp1_ready", 32'(bus_if.req_ready), 32'h0);
        check("b2b/resp1_rdata", bus_if.resp_rdata, 32'h80ADBEEF);
        tick();
        check("b2b/idle_ready", 32'(bus_if.req_ready), 32'h1);
        check("b2b/idle_valid", 32'(bus_if.resp_valid), 32'h0);
        tick();
        check("b2b/issue2_ready", 32'(bus_if.req_ready), 32'h0);
        check("b2b/issue2_addr", 32'(bus_if.mem_addr), 32'h8);
        bus_if.req_valid = 1'b0;
        tick();
        tick();
        check("b2b/resp2_valid", 32'(bus_if.resp_valid), 32'h1);
        check("b2b/resp2_rdata", bus_if.resp_rdata, 32'h1234AAAA);
        tick();

        // Reset pulse while a store sits in ISSUE.
        run_req("st_w_40",    1'b1, W_WORD, 1'b0, 32'h40,       32'h00000000, 2, 4'hF, 32'h10, 32'h0,       32'h0,        1'b0);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_width = W_WORD;
        bus_if.req_addr  = 32'h40;
        bus_if.req_wdata = 32'h11111111;
        tick();
        check("abort/issue_we", 32'(bus_if.mem_write_en), 32'hF);
        bus_if.req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort/write_en", 32'(bus_if.mem_write_en), 32'h0);
        check("abort/resp_valid", 32'(bus_if.resp_valid), 32'h0);
        check("abort/ready", 32'(bus_if.req_ready), 32'h1);
        check("abort/mem_addr", 32'(bus_if.mem_addr), 32'h0);
        check("abort/mem_din", bus_if.mem_din, 32'h0);
        check("abort/rdata", bus_if.resp_rdata, 32'h0);
        check("abort/misaligned", 32'(bus_if.resp_misaligned), 32'h0);
        #2;
        reset_n = 1'b1;
        resp_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            resp_seen |= bus_if.resp_valid;
        end
        check("abort/no_resp", 32'(resp_seen), 32'h0);
        check("abort/idle_ready", 32'(bus_if.req_ready), 32'h1);
        run_req("ld_w_40",    1'b0, W_WORD, 1'b0, 32'h40,       32'h0,        3, 4'h0, 32'h10, 32'h0,       32'h00000000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 14, word-address width of the attached 32-bit byte-enabled synchronous RAM.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_width  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_misaligned  output  1  qualifies resp_valid; access rejected.
REQ-014 mem_addr  output  ADDR_WIDTH  RAM word address.
REQ-015 mem_din  output  32  RAM write data.
REQ-016 mem_write_en  output  4  RAM per-byte write enables.
REQ-017 mem_dout  input  32  RAM read data, valid one cycle after mem_addr is presented.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Acceptance (cycle T, IDLE, req_valid=1): aligned -> ISSUE; misaligned -> RESP with resp_misaligned=1, no RAM access.
REQ-020 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; width 11 at any address.
REQ-021 ISSUE (T+1): mem_addr = req_addr[ADDR_WIDTH+1:2] (upper bits ignored), all mem_* outputs registered; store -> RESP, load -> WAIT.
REQ-022 mem_write_en nonzero only in ISSUE of a store: byte 4'b0001<<addr[1:0], half 4'b0011<<(2*addr[1]), word 4'b1111.
REQ-023 mem_din: byte replicated x4, half replicated x2, word unchanged.
REQ-024 WAIT (T+2): capture mem_dout shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half), extended per req_unsigned -> RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE; latency misaligned T+1, store T+2, load T+3.
REQ-026 resp_rdata and resp_misaligned SHALL hold their values until the next response; no backpressure on response.
REQ-027 mem_addr SHALL hold its last value when idle; request inputs are sampled only at acceptance.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_write_en=0, mem_addr=0, mem_din=0.
REQ-029 Reset asserted in ISSUE SHALL drop mem_write_en asynchronously; the aborted request produces no response.

Structure
REQ-030 Package mem_access_pkg SHALL hold width encodings (BYTE/HALF/WORD) and the FSM state enum.
REQ-031 Sub-module load_align_ext (combinational: mem_dout, addr[1:0], width, unsigned -> 32-bit result) SHALL be used for REQ-024.

Verification
REQ-032 Store word 0xDEADBEEF @0x10 then load word @0x10 -> write_en 1111 at T+1, mem_addr=4; load resp T+3 rdata 0xDEADBEEF.
REQ-033 Store byte 0x80 @0x13, load byte signed @0x13 -> write_en 1000, mem_din 0x80808080; rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Store half 0x1234 @0x22 over 0xAAAAAAAA at word 8 -> write_en 1100; load word -> 0x1234AAAA.
REQ-035 Load half @0x01, word @0x06, width 11 @0x00 -> resp_valid at T+1, misaligned=1, rdata 0, write_en never nonzero.
REQ-036 Back-to-back req_valid held high -> req_ready low T+1..response, second request accepted the cycle after RESP.
REQ-037 reset_n pulsed low during ISSUE of a store -> write_en 0 same cycle, no resp_valid, IDLE with all outputs at reset values.
